fifo_axis_ext: RTL and testbench

- Generalised AXI-Stream synchronous FIFO for the cipher datapath, e.g. buffering keystream/plaintext between the ChaCha20 core and the DMA-facing stream.
- Carries TDATA, TLAST and TUSER, and uses all DEPTH storage entries.
- Drives an AXIS-compliant registered output: TVALID is held until the beat is accepted.
- Reports fill level and almost-full/almost-empty flags.
- Optionally runs in store-and-forward packet mode.

---
 rtl/fifo_axis_pkg.sv | 40 ++++
 rtl/fifo_axis_ram.sv | 29 ++
 rtl/fifo_axis_ext.sv | 174 +++++++++++++++++
 tb/tb_fifo_axis_ext.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_axis_pkg.sv
// fifo_axis_pkg: shared sizing helpers and entry layout for the AXI-Stream FIFO.
// Latency: none (constants and constant functions only).
// Backpressure: not applicable.
package fifo_axis_pkg;

  // Pointers carry one extra wrap bit above the array address.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // The count must reach DEPTH+1 (full array plus a loaded output register).
  // clog2(DEPTH)+1 bits hold up to 2*DEPTH-1, which covers this for every DEPTH >= 2.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Stored entry is packed as {tuser, tlast, tdata}.
  function automatic int entry_width(input int data_w, input int user_w);
    return data_w + 1 + user_w;
  endfunction

  // TLAST sits directly above TDATA.
  function automatic int last_pos(input int data_w);
    return data_w;
  endfunction

  // TUSER starts directly above TLAST.
  function automatic int user_off(input int data_w);
    return data_w + 1;
  endfunction

  // Handshake combination seen in a cycle: {input accepted, output accepted}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_axis_ram.sv
// fifo_axis_ram: simple dual-port storage, one synchronous write port and one asynchronous read port.
// Latency: a write lands on the clock edge; a read is combinational from the address.
// Backpressure: none; the caller guarantees it never writes a slot that is still unread.
module fifo_axis_ram #(
  parameter int C_WIDTH      = 34,
  parameter int C_ADDR_WIDTH = 4
) (
  input  logic                    i_aclk,
  input  logic                    wr_en,
  input  logic [C_ADDR_WIDTH-1:0] wr_addr,
  input  logic [C_WIDTH-1:0]      wr_data,
  input  logic [C_ADDR_WIDTH-1:0] rd_addr,
  output logic [C_WIDTH-1:0]      rd_data
);

  localparam int C_ENTRIES = 2 ** C_ADDR_WIDTH;

  logic [C_WIDTH-1:0] mem [C_ENTRIES];

  // Storage has no reset; contents are only meaningful between the pointers.
  always_ff @(posedge i_aclk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_axis_ext.sv
// fifo_axis_ext: AXI-Stream FIFO carrying TDATA/TLAST/TUSER, with fill level and almost-full/empty flags.
// Latency: a beat written into an empty FIFO is presented on m_axis one cycle after its acceptance.
// Backpressure: s_axis_tready drops only while the array is full; m_axis holds stable while stalled.
// Optional store-and-forward packet mode is enabled by defining FIFO_AXIS_PKT_MODE_EN.
module fifo_axis_ext
  import fifo_axis_pkg::*;
#(
  parameter int C_FIFO_WIDTH   = 32,
  parameter int C_USER_WIDTH   = 1,
  parameter int C_FIFO_DEPTH   = 16,
  parameter int C_ALMOST_FULL  = 14,
  parameter int C_ALMOST_EMPTY = 2
) (
  input  logic                          i_aclk,
  input  logic                          i_aresetn,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tvalid,
  input  logic [C_FIFO_WIDTH-1:0]       s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic [C_USER_WIDTH-1:0]       s_axis_tuser,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tvalid,
  output logic [C_FIFO_WIDTH-1:0]       m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [C_USER_WIDTH-1:0]       m_axis_tuser,
  output logic [$clog2(C_FIFO_DEPTH):0] o_count,
  output logic                          o_almost_full,
  output logic                          o_almost_empty
);

  localparam int AW       = $clog2(C_FIFO_DEPTH);
  localparam int PW       = ptr_width(C_FIFO_DEPTH);
  localparam int CW       = cnt_width(C_FIFO_DEPTH);
  localparam int EW       = entry_width(C_FIFO_WIDTH, C_USER_WIDTH);
  localparam int LAST_POS = last_pos(C_FIFO_WIDTH);
  localparam int USER_OFF = user_off(C_FIFO_WIDTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          arr_empty;
  logic          arr_full;
  logic          rst_done;
  logic          wr_en;
  logic          out_acc;
  logic          load;
  logic          pkt_ok;
  logic [EW-1:0] wr_data;
  logic [EW-1:0] rd_data;
  logic [CW-1:0] count_nxt;
  fifo_op_e      count_op;

  // Equal pointers mean empty; same slot on opposite laps means every entry is in use.
  assign arr_empty = (wr_ptr == rd_ptr);
  assign arr_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Ready comes from registered state only, so there is no path from m_axis_tready.
  assign s_axis_tready = rst_done && !arr_full;
  assign wr_en         = s_axis_tvalid && s_axis_tready;
  assign out_acc       = m_axis_tvalid && m_axis_tready;
  assign wr_data       = {s_axis_tuser, s_axis_tlast, s_axis_tdata};

  // Refill the output register whenever it is empty or being drained this cycle.
  assign load = !arr_empty && pkt_ok && (!m_axis_tvalid || m_axis_tready);

`ifdef FIFO_AXIS_PKT_MODE_EN
  logic [PW-1:0] pkt_cnt;
  logic [PW-1:0] pkt_cnt_nxt;
  fifo_op_e      pkt_op;

  // Hold the output back until a whole packet is stored, unless the array is full:
  // a packet longer than the array would otherwise never see its TLAST written.
  assign pkt_ok = (pkt_cnt != '0) || arr_full;

  // Complete packets held in the array: +1 when a TLAST beat is written, -1 when one is loaded out.
  always_comb begin
    pkt_op      = fifo_op_e'({wr_en && s_axis_tlast, load && rd_data[LAST_POS]});
    pkt_cnt_nxt = pkt_cnt;
    case (pkt_op)
      OP_WR:   pkt_cnt_nxt = pkt_cnt + PW'(1);
      OP_RD:   pkt_cnt_nxt = pkt_cnt - PW'(1);
      default: pkt_cnt_nxt = pkt_cnt;
    endcase
  end

  // Packet counter register.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      pkt_cnt <= '0;
    end else begin
      pkt_cnt <= pkt_cnt_nxt;
    end
  end
`else
  assign pkt_ok = 1'b1;
`endif

  fifo_axis_ram #(
    .C_WIDTH      (EW),
    .C_ADDR_WIDTH (AW)
  ) u_ram (
    .i_aclk  (i_aclk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  // Ready stays low while reset is held and rises on the first edge after release.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  // Pointers advance freely and wrap modulo 2*DEPTH through their natural width.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (load) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Output register: load a new beat, drop valid only when drained with nothing to replace it.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= rd_data[C_FIFO_WIDTH-1:0];
      m_axis_tlast  <= rd_data[LAST_POS];
      m_axis_tuser  <= rd_data[USER_OFF +: C_USER_WIDTH];
    end else if (out_acc) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Beats held across array and output register: +1 on input accept, -1 on output accept.
  always_comb begin
    count_op  = fifo_op_e'({wr_en, out_acc});
    count_nxt = o_count;
    case (count_op)
      OP_WR:   count_nxt = o_count + CW'(1);
      OP_RD:   count_nxt = o_count - CW'(1);
      default: count_nxt = o_count;
    endcase
  end

  // Count and flags update together from the next-state count so they always agree.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_count        <= '0;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
    end else begin
      o_count        <= count_nxt;
      o_almost_full  <= (int'(count_nxt) >= C_ALMOST_FULL);
      o_almost_empty <= (int'(count_nxt) <= C_ALMOST_EMPTY);
    end
  end

endmodule

// File: tb/tb_fifo_axis_ext.sv
// tb_fifo_axis_ext: queue-based reference model with a per-cycle compare, plus directed scenarios.
// Inputs change on the falling clock edge; outputs are compared 1 ns after it.
// The model keeps the array contents as a queue and the output register as a single slot.
module tb_fifo_axis_ext;

  localparam int DW    = 32;
  localparam int UW    = 1;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  typedef struct packed {
    logic [UW-1:0] user;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          i_aclk        = 1'b0;
  logic          i_aresetn     = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] s_axis_tdata  = '0;
  logic          s_axis_tlast  = 1'b0;
  logic [UW-1:0] s_axis_tuser  = '0;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic [UW-1:0] m_axis_tuser;
  logic [4:0]    o_count;
  logic          o_almost_full;
  logic          o_almost_empty;

  fifo_axis_ext #(
    .C_FIFO_WIDTH   (DW),
    .C_USER_WIDTH   (UW),
    .C_FIFO_DEPTH   (DEPTH),
    .C_ALMOST_FULL  (AF),
    .C_ALMOST_EMPTY (AE)
  ) dut (
    .i_aclk         (i_aclk),
    .i_aresetn      (i_aresetn),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tuser   (s_axis_tuser),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .o_count        (o_count),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty)
  );

  always #5 i_aclk = ~i_aclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  beat_t         q_arr[$];
  beat_t         m_out    = '0;
  bit            m_vld    = 1'b0;
  bit            up       = 1'b0;
  int            cyc      = 0;
  int            first_in = -1;
  int            first_vld = -1;
  int            peak     = 0;
  bit            track_peak = 1'b0;
  logic [DW-1:0] out_log[$];

  function automatic int lasts_held();
    int n = 0;
    foreach (q_arr[i]) if (q_arr[i].last) n++;
    return n;
  endfunction

  task automatic model_step();
    bit in_fire;
    bit out_fire;
    bit load;
    if (!i_aresetn) begin
      q_arr.delete();
      m_vld = 1'b0;
      m_out = '0;
      up    = 1'b0;
    end else begin
      cyc++;
      in_fire  = s_axis_tvalid && up && (q_arr.size() < DEPTH);
      out_fire = m_vld && m_axis_tready;
      load     = (q_arr.size() > 0) && (!m_vld || m_axis_tready);
`ifdef FIFO_AXIS_PKT_MODE_EN
      load     = load && ((lasts_held() > 0) || (q_arr.size() == DEPTH));
`endif
      if (load) begin
        m_out = q_arr.pop_front();
        m_vld = 1'b1;
      end else if (out_fire) begin
        m_vld = 1'b0;
      end
      if (in_fire) begin
        q_arr.push_back('{user: s_axis_tuser, last: s_axis_tlast, data: s_axis_tdata});
        if (first_in < 0) first_in = cyc;
      end
      up = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge i_aclk or negedge i_aresetn);
    model_step();
  end

  // Per-cycle comparison against the model.
  initial forever begin
    int cnt;
    @(negedge i_aclk);
    #1;
    cnt = q_arr.size() + int'(m_vld);
    check("s_tready",     s_axis_tready, up && (q_arr.size() < DEPTH));
    check("m_tvalid",     m_axis_tvalid, m_vld);
    check("m_tdata",      m_axis_tdata,  m_out.data);
    check("m_tlast",      m_axis_tlast,  m_out.last);
    check("m_tuser",      m_axis_tuser,  m_out.user);
    check("o_count",      o_count,       cnt);
    check("almost_full",  o_almost_full,  cnt >= AF);
    check("almost_empty", o_almost_empty, cnt <= AE);
    if (m_axis_tvalid && m_axis_tready) out_log.push_back(m_axis_tdata);
    if (m_axis_tvalid && first_vld < 0) first_vld = cyc;
    if (track_peak && int'(o_count) > peak) peak = int'(o_count);
  end

  task automatic put(input logic [DW-1:0] d, input logic l, input logic [UW-1:0] u);
    int guard;
    guard = 0;
    @(negedge i_aclk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    while (!s_axis_tready && guard < 200) begin
      @(negedge i_aclk);
      guard++;
    end
    check("put_timeout", guard < 200, 1'b1);
  endtask

  task automatic idle();
    @(negedge i_aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  initial begin
    int            acc;
    int            outs;
    int            af_first;
    logic [DW-1:0] seq;
    logic [DW-1:0] hd;
    logic          hl;
    logic [UW-1:0] hu;
    bit            flag;

    // Reset state.
    repeat (3) @(negedge i_aclk);
    #2;
    check("rst_s_tready", s_axis_tready, 1'b0);
    check("rst_almost_empty", o_almost_empty, 1'b1);
    check("rst_count", o_count, 0);
    @(negedge i_aclk);
    i_aresetn = 1'b1;
    @(negedge i_aclk);
    #2;
    check("post_rst_s_tready", s_axis_tready, 1'b1);

    // Four beats 0x11..0x14 through an always-ready sink.
    @(negedge i_aclk);
    m_axis_tready = 1'b1;
    track_peak = 1'b1;
    out_log.delete();
    for (int i = 0; i < 4; i++) put(DW'(32'h11 + i), (i == 3), UW'(i & 1));
    idle();
    repeat (6) @(negedge i_aclk);
    track_peak = 1'b0;
    check("t1_beats", out_log.size(), 4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) check("t1_order", out_log[i], 32'h11 + i);
`ifndef FIFO_AXIS_PKT_MODE_EN
    check("t1_latency", first_vld - first_in, 1);
    check("t1_peak_le2", peak <= 2, 1'b1);
`endif

    // Fill with the sink stalled: 16 array entries plus the output register.
    @(negedge i_aclk);
    m_axis_tready = 1'b0;
    seq = 32'h100;
    acc = 0;
    af_first = -1;
    for (int c = 0; c < 25; c++) begin
      @(negedge i_aclk);
      if (o_almost_full && af_first < 0) af_first = int'(o_count);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = seq;
      s_axis_tlast  = (seq[1:0] == 2'd3);
      s_axis_tuser  = seq[0];
      if (s_axis_tready) begin
        seq = seq + 1;
        acc++;
      end
    end
    #2;
    check("t2_accepted", acc, 17);
    check("t2_count", o_count, 17);
    check("t2_s_tready", s_axis_tready, 1'b0);
    check("t2_almost_full", o_almost_full, 1'b1);
    check("t2_af_first", af_first, 14);

    // Full FIFO streaming both ways for 100 cycles.
    acc = 0;
    outs = 0;
    flag = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge i_aclk);
      if (c >= 1 && o_count != 5'd16) flag = 1'b0;
      m_axis_tready = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = seq;
      s_axis_tlast  = (seq[1:0] == 2'd3);
      s_axis_tuser  = seq[0];
      if (s_axis_tready) begin
        seq = seq + 1;
        acc++;
      end
      if (m_axis_tvalid) outs++;
    end
    check("t3_outs", outs, 100);
    check("t3_ins", acc, 99);
    check("t3_count_const", flag, 1'b1);

    // Stall with valid held: the beat must not change, then exactly the next one follows.
    @(negedge i_aclk);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    hd = m_axis_tdata;
    hl = m_axis_tlast;
    hu = m_axis_tuser;
    flag = 1'b1;
    repeat (5) begin
      @(negedge i_aclk);
      #2;
      if (!m_axis_tvalid || m_axis_tdata !== hd || m_axis_tlast !== hl || m_axis_tuser !== hu) flag = 1'b0;
    end
    check("t4_hold_stable", flag, 1'b1);
    @(negedge i_aclk);
    m_axis_tready = 1'b1;
    @(negedge i_aclk);
    m_axis_tready = 1'b0;
    #2;
    check("t4_next_valid", m_axis_tvalid, 1'b1);
    check("t4_next_data", m_axis_tdata, hd + 1);

    // Drain, then reset mid-stream with 7 beats stored.
    @(negedge i_aclk);
    m_axis_tready = 1'b1;
    repeat (40) @(negedge i_aclk);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 7; i++) put(DW'(32'hA0 + i), 1'b0, '0);
    idle();
    #2;
    check("t5_count7", o_count, 7);
    #1;
    i_aresetn = 1'b0;
    #1;
    check("t5_rst_tvalid", m_axis_tvalid, 1'b0);
    check("t5_rst_tdata", m_axis_tdata, 0);
    check("t5_rst_tlast", m_axis_tlast, 1'b0);
    check("t5_rst_tuser", m_axis_tuser, 0);
    check("t5_rst_count", o_count, 0);
    check("t5_rst_ae", o_almost_empty, 1'b1);
    check("t5_rst_af", o_almost_full, 1'b0);
    check("t5_rst_s_tready", s_axis_tready, 1'b0);
    repeat (2) @(negedge i_aclk);
    i_aresetn = 1'b1;
    m_axis_tready = 1'b1;
    outs = 0;
    repeat (10) begin
      @(negedge i_aclk);
      if (m_axis_tvalid) outs++;
    end
    check("t5_no_stale", outs, 0);
    check("t5_count_after", o_count, 0);
    out_log.delete();
    for (int i = 0; i < 5; i++) put(DW'(32'hB0 + i), (i == 4), '0);
    idle();
    repeat (8) @(negedge i_aclk);
    check("t5_fresh_beats", out_log.size(), 5);
    for (int i = 0; i < 5 && i < out_log.size(); i++) check("t5_fresh_order", out_log[i], 32'hB0 + i);

`ifdef FIFO_AXIS_PKT_MODE_EN
    // Store-and-forward: nothing leaves until TLAST is stored.
    out_log.delete();
    put(32'hC0, 1'b0, '0);
    put(32'hC1, 1'b0, '0);
    idle();
    flag = 1'b0;
    repeat (10) begin
      @(negedge i_aclk);
      if (m_axis_tvalid) flag = 1'b1;
    end
    check("pkt_held", flag, 1'b0);
    put(32'hC2, 1'b1, '0);
    idle();
    repeat (6) @(negedge i_aclk);
    check("pkt_beats", out_log.size(), 3);
    // Packet longer than the array must cut through.
    out_log.delete();
    for (int i = 0; i < 20; i++) put(DW'(32'hD00 + i), (i == 19), '0);
    idle();
    repeat (40) @(negedge i_aclk);
    check("pkt_long_beats", out_log.size(), 20);
    if (out_log.size() > 0) check("pkt_long_last", out_log[out_log.size()-1], 32'hD13);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
